// File: rtl/logarithm.sv
// ============================================================================
// Module   : logarithm
// Purpose  : Registered ceil(log2(N)) with power-of-two and saturation flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module logarithm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] N,
    input  logic        in_valid,
    output logic [4:0]  bitnum,
    output logic        is_pow2,
    output logic        sat,
    output logic        out_valid
);

    localparam logic [4:0] C_BITNUM_MAX = 5'd31;

    logic [31:0] w_search;
    logic [4:0]  w_msb;
    logic        w_pow2;
    logic [5:0]  w_ceil;

    logic [4:0]  bitnum_d,    bitnum_q;
    logic        is_pow2_d,   is_pow2_q;
    logic        sat_d,       sat_q;
    logic        out_valid_d, out_valid_q;

    // Binary-search MSB finder: each stage halves the window still holding the top 1.
    always_comb begin
        w_search = N;
        w_msb    = 5'd0;
        if (w_search[31:16] != 16'd0) begin
            w_msb[4] = 1'b1;
            w_search = w_search >> 16;
        end
        if (w_search[15:8] != 8'd0) begin
            w_msb[3] = 1'b1;
            w_search = w_search >> 8;
        end
        if (w_search[7:4] != 4'd0) begin
            w_msb[2] = 1'b1;
            w_search = w_search >> 4;
        end
        if (w_search[3:2] != 2'd0) begin
            w_msb[1] = 1'b1;
            w_search = w_search >> 2;
        end
        if (w_search[1]) begin
            w_msb[0] = 1'b1;
        end
    end

    // A 6-bit ceil result lets N > 2^31 express the true value 32 before saturating.
    always_comb begin
        w_pow2 = (N != 32'd0) && ((N & (N - 32'd1)) == 32'd0);
        if (N == 32'd0) begin
            w_ceil = 6'd0;
        end else if (w_pow2) begin
            w_ceil = {1'b0, w_msb};
        end else begin
            w_ceil = {1'b0, w_msb} + 6'd1;
        end
    end

    always_comb begin
        bitnum_d    = bitnum_q;
        is_pow2_d   = is_pow2_q;
        sat_d       = sat_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            is_pow2_d = w_pow2;
            sat_d     = w_ceil[5];
            bitnum_d  = w_ceil[5] ? C_BITNUM_MAX : w_ceil[4:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitnum_q    <= 5'd0;
            is_pow2_q   <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            bitnum_q    <= bitnum_d;
            is_pow2_q   <= is_pow2_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bitnum    = bitnum_q;
    assign is_pow2   = is_pow2_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_logarithm.sv
// ============================================================================
// Module   : tb_logarithm
// Purpose  : Self-checking bench for logarithm against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_logarithm;

    logic        clk;
    logic        rst;
    logic [31:0] N;
    logic        in_valid;
    logic [4:0]  bitnum;
    logic        is_pow2;
    logic        sat;
    logic        out_valid;

    int checks;
    int failures;

    logic [4:0] exp_bitnum;
    logic       exp_pow2;
    logic       exp_sat;
    logic       exp_valid;

    logarithm dut (
        .clk       (clk),
        .rst       (rst),
        .N         (N),
        .in_valid  (in_valid),
        .bitnum    (bitnum),
        .is_pow2   (is_pow2),
        .sat       (sat),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Smallest k with 2^k >= n, computed in 64-bit arithmetic so 32 is representable.
    function automatic void model(input logic [31:0] n, output logic [4:0] b,
                                  output logic p, output logic s);
        longint unsigned v;
        int k;
        v = 64'(n);
        k = 0;
        while ((64'd1 << k) < v) k++;
        p = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (v == (64'd1 << i)) p = 1'b1;
        end
        s = (k > 31);
        b = s ? 5'd31 : 5'(k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".bitnum"},    32'(bitnum),    32'(exp_bitnum));
        chk({tag, ".is_pow2"},   32'(is_pow2),   32'(exp_pow2));
        chk({tag, ".sat"},       32'(sat),       32'(exp_sat));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    // Drive one input on the falling edge, then check one step after the capturing edge.
    task automatic apply(input logic [31:0] n, input logic v, input string tag);
        logic [4:0] b;
        logic p, s;
        @(negedge clk);
        N        = n;
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) begin
            model(n, b, p, s);
            exp_bitnum = b;
            exp_pow2   = p;
            exp_sat    = s;
        end
        exp_valid = v;
        chk_all(tag);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        N          = 32'd0;
        in_valid   = 1'b0;
        exp_bitnum = 5'd0;
        exp_pow2   = 1'b0;
        exp_sat    = 1'b0;
        exp_valid  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b0;
        apply(32'd0, 1'b0, "idle_after_reset");

        for (int i = 0; i <= 20; i++) apply(32'(i), 1'b1, "sweep");
        for (int k = 0; k < 32; k++) apply(32'd1 << k, 1'b1, "pow2");
        for (int k = 1; k <= 30; k++) apply((32'd1 << k) + 32'd1, 1'b1, "pow2_plus1");
        apply(32'h8000_0000, 1'b1, "top_pow2");
        apply(32'h8000_0001, 1'b1, "sat_low");
        apply(32'hFFFF_FFFF, 1'b1, "sat_high");

        apply(32'd7, 1'b1, "gate_load");
        apply(32'd100, 1'b0, "gate_hold");

        // Reset asserted mid-cycle with a result valid and another in flight.
        apply(32'd5, 1'b1, "pre_reset");
        @(negedge clk);
        N        = 32'd1000;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        exp_bitnum = 5'd0;
        exp_pow2   = 1'b0;
        exp_sat    = 1'b0;
        exp_valid  = 1'b0;
        chk_all("async_reset");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        apply(32'd1000, 1'b0, "post_reset_idle");
        apply(32'd1000, 1'b1, "post_reset_first");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom >> $urandom_range(31, 0);
            if ($urandom_range(7, 0) == 0) r = 32'd1 << $urandom_range(31, 0);
            apply(r, 1'($urandom_range(3, 0) != 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
